// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the round-robin DDR channel arbiter: FSM encoding,
// bus op codes and the grant-index width helper.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic DBUS_OP_READ  = 1'b0;
  localparam logic DBUS_OP_WRITE = 1'b1;

  function automatic int gidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_channel_arb_rr_arbiter.sv
// Combinational rotate-priority selector: picks the first requester at or
// after i_ptr, wrapping modulo NUM_CH.
module rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int GW     = gidx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [GW-1:0]     i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [GW-1:0]     o_gidx,
  output logic              o_any
);

  logic [GW-1:0] w_idx;
  logic          w_hit;

  // scan channels in rotated order, first hit wins
  always_comb begin
    o_grant = '0;
    o_gidx  = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx          = GW'((int'(i_ptr) + i) % NUM_CH);
      w_hit          = !o_any && i_req[w_idx];
      o_grant[w_idx] = o_grant[w_idx] | w_hit;
      o_gidx         = w_hit ? w_idx : o_gidx;
      o_any          = o_any | w_hit;
    end
  end

endmodule

// File: rtl/ddr_channel_arb_rr.sv
// N-channel round-robin arbiter in front of a single-port DDR model, with
// per-channel response flush and a completion timeout.
module ddr_channel_arb_rr
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_index,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH-1:0]        req_burst,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*DATA_W-1:0] req_wmask,
  input  logic [NUM_CH-1:0]        req_flush,
  output logic [NUM_CH-1:0]        resp_done,
  output logic                     resp_err,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     ddr_chip_enable,
  output logic [ADDR_W-1:0]        ddr_index,
  output logic                     ddr_write_enable,
  output logic                     ddr_burst_mode,
  output logic [DATA_W-1:0]        ddr_write_data,
  output logic [DATA_W-1:0]        ddr_write_mask,
  input  logic [DATA_W-1:0]        ddr_read_data,
  input  logic                     ddr_operation_done,
  input  logic                     ddr_ready
);

  localparam int              GW      = gidx_w(NUM_CH);
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e          r_state, w_next_state;
  logic [GW-1:0]       r_ptr, r_gidx, w_gidx;
  logic [NUM_CH-1:0]   w_grant;
  logic                w_any, w_fire, w_done_hit, w_to_hit, w_drop;
  logic                r_drop;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ce, r_we, r_burst, r_resp_err;
  logic [ADDR_W-1:0]   r_index, w_sel_index;
  logic [DATA_W-1:0]   r_wdata, r_wmask, r_rdata, w_sel_wdata, w_sel_wmask;
  logic [NUM_CH-1:0]   r_resp_done;

  rr_arbiter #(.NUM_CH(NUM_CH), .GW(GW)) u_rr (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_gidx (w_gidx),
    .o_any  (w_any)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // next-state decode; done in the final wait cycle beats the timeout
  always_comb begin
    w_next_state = r_state;
    w_fire       = 1'b0;
    w_done_hit   = 1'b0;
    w_to_hit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && ddr_ready) begin
          w_fire       = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (ddr_operation_done) begin
          w_done_hit   = 1'b1;
          w_next_state = ST_IDLE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_to_hit     = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // granted-channel field mux (grant is one-hot, so AND-OR is exact)
  always_comb begin
    w_sel_index = '0;
    w_sel_wdata = '0;
    w_sel_wmask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel_index = w_sel_index | ({ADDR_W{w_grant[c]}} & req_index[c*ADDR_W +: ADDR_W]);
      w_sel_wdata = w_sel_wdata | ({DATA_W{w_grant[c]}} & req_wdata[c*DATA_W +: DATA_W]);
      w_sel_wmask = w_sel_wmask | ({DATA_W{w_grant[c]}} & req_wmask[c*DATA_W +: DATA_W]);
    end
  end

  assign req_ready = w_fire ? w_grant : '0;
  assign w_drop    = r_drop | req_flush[r_gidx];

  // request latch, timeout counter, response and pointer update
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_drop      <= 1'b0;
      r_cnt       <= '0;
      r_ce        <= 1'b0;
      r_we        <= DBUS_OP_READ;
      r_burst     <= 1'b0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rdata     <= '0;
      r_resp_done <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_ce        <= w_fire;
      r_resp_done <= '0;
      r_resp_err  <= 1'b0;
      if (w_fire) begin
        r_gidx  <= w_gidx;
        r_drop  <= |(w_grant & req_flush);
        r_cnt   <= '0;
        r_we    <= |(w_grant & req_write);
        r_burst <= |(w_grant & req_burst);
        r_index <= w_sel_index;
        r_wdata <= w_sel_wdata;
        r_wmask <= w_sel_wmask;
      end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
        r_drop <= w_drop;
      end
      if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_done_hit || w_to_hit) begin
        r_ptr <= (r_gidx == GW'(NUM_CH - 1)) ? '0 : r_gidx + 1'b1;
        if (!w_drop) begin
          r_resp_done <= {{(NUM_CH-1){1'b0}}, 1'b1} << r_gidx;
          r_resp_err  <= w_to_hit && !w_done_hit;
          if (w_done_hit && (r_we == DBUS_OP_READ)) r_rdata <= ddr_read_data;
        end
      end
    end
  end

  assign resp_done        = r_resp_done;
  assign resp_err         = r_resp_err;
  assign resp_rdata       = r_rdata;
  assign ddr_chip_enable  = r_ce;
  assign ddr_index        = r_index;
  assign ddr_write_enable = r_we;
  assign ddr_burst_mode   = r_burst;
  assign ddr_write_data   = r_wdata;
  assign ddr_write_mask   = r_wmask;

endmodule

// File: tb/tb_ddr_channel_arb_rr.sv
// Directed self-checking bench for ddr_channel_arb_rr (4 channels, TIMEOUT=16).
module tb_ddr_channel_arb_rr;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic [NUM_CH-1:0]        req_valid, req_ready, req_write, req_burst, req_flush, resp_done;
  logic [NUM_CH*ADDR_W-1:0] req_index;
  logic [NUM_CH*DATA_W-1:0] req_wdata, req_wmask;
  logic                     resp_err, ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  logic [DATA_W-1:0]        resp_rdata, ddr_write_data, ddr_write_mask, ddr_read_data;
  logic [ADDR_W-1:0]        ddr_index;
  logic                     ddr_operation_done, ddr_ready;

  int errors = 0;
  int checks = 0;

  ddr_channel_arb_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .TIMEOUT(16), .CNT_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_write(req_write), .req_burst(req_burst), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .req_flush(req_flush),
    .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_data(ddr_write_data), .ddr_write_mask(ddr_write_mask),
    .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
    .ddr_ready(ddr_ready)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", resp_done); end
    checks++; if (ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", ddr_chip_enable); end
    checks++; if (ddr_index !== 64'h0) begin errors++; $display("FAIL reset_index got=%h exp=0", ddr_index); end
    checks++; if (resp_rdata !== {DATA_W{1'b0}}) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    reset_n   = 1'b1;
    ddr_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ddr_not_ready_ready got=%b exp=0000", req_ready); end
    cyc();
    checks++; if (ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL ddr_not_ready_ce got=%b exp=0", ddr_chip_enable); end
    req_valid = 4'b0000;
    ddr_ready = 1'b1;
  endtask

  task automatic test_single_read();
    req_index[1*ADDR_W +: ADDR_W] = 64'h80;
    req_burst = 4'b0010;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready got=%b exp=0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    req_burst = 4'b0000;
    checks++; if (ddr_chip_enable !== 1'b1) begin errors++; $display("FAIL rd_ce got=%b exp=1", ddr_chip_enable); end
    checks++; if (ddr_index !== 64'h80) begin errors++; $display("FAIL rd_index got=%h exp=80", ddr_index); end
    checks++; if (ddr_burst_mode !== 1'b1 || ddr_write_enable !== 1'b0) begin errors++; $display("FAIL rd_flags got=%b%b exp=10", ddr_burst_mode, ddr_write_enable); end
    cyc();
    checks++; if (ddr_chip_enable !== 1'b0) begin errors++; $display("FAIL rd_ce_pulse got=%b exp=0", ddr_chip_enable); end
    repeat (4) cyc();
    checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL rd_early_done got=%b exp=0000", resp_done); end
    ddr_operation_done = 1'b1;
    ddr_read_data      = {64{8'hAB}};
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0010) begin errors++; $display("FAIL rd_done got=%b exp=0010", resp_done); end
    checks++; if (resp_rdata !== {64{8'hAB}}) begin errors++; $display("FAIL rd_rdata got=%h exp=ab..", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", resp_err); end
    cyc();
    checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL rd_done_pulse got=%b exp=0000", resp_done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] prev_g;
    logic [7:0] b;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) req_index[c*ADDR_W +: ADDR_W] = 64'h1000 + 64'(c);
    prev_g = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i > 0) begin
        checks++; if (resp_done !== prev_g) begin errors++; $display("FAIL rr_done[%0d] got=%b exp=%b", i, resp_done, prev_g); end
      end
      ddr_operation_done = 1'b0;
      req_valid = 4'b1111;
      exp_g = 4'b0001 << (i % 4);
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_g); end
      cyc();
      checks++; if (ddr_index !== 64'h1000 + 64'(i % 4)) begin errors++; $display("FAIL rr_index[%0d] got=%h exp=%h", i, ddr_index, 64'h1000 + 64'(i % 4)); end
      cyc();
      b = 8'h10 + 8'(i);
      ddr_operation_done = 1'b1;
      ddr_read_data = {64{b}};
      prev_g = exp_g;
    end
    cyc();
    req_valid = 4'b0000;
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0001) begin errors++; $display("FAIL rr_done_last got=%b exp=0001", resp_done); end
  endtask

  task automatic test_write();
    cyc();
    req_index[3*ADDR_W +: ADDR_W] = 64'h3C0;
    req_wdata[3*DATA_W +: DATA_W] = {64{8'h55}};
    req_wmask[3*DATA_W +: DATA_W] = {DATA_W{1'b1}};
    req_write = 4'b1000;
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wr_ready got=%b exp=1000", req_ready); end
    cyc();
    req_valid = 4'b0000;
    req_write = 4'b0000;
    checks++; if (ddr_chip_enable !== 1'b1 || ddr_write_enable !== 1'b1) begin errors++; $display("FAIL wr_ce_we got=%b%b exp=11", ddr_chip_enable, ddr_write_enable); end
    checks++; if (ddr_write_data !== {64{8'h55}}) begin errors++; $display("FAIL wr_data got=%h exp=55..", ddr_write_data); end
    checks++; if (ddr_write_mask !== {DATA_W{1'b1}}) begin errors++; $display("FAIL wr_mask got=%h exp=ff..", ddr_write_mask); end
    checks++; if (ddr_index !== 64'h3C0) begin errors++; $display("FAIL wr_index got=%h exp=3c0", ddr_index); end
    cyc();
    ddr_operation_done = 1'b1;
    ddr_read_data = {64{8'hEE}};
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b1000 || resp_err !== 1'b0) begin errors++; $display("FAIL wr_done got=%b/%b exp=1000/0", resp_done, resp_err); end
    checks++; if (resp_rdata !== {64{8'h14}}) begin errors++; $display("FAIL wr_rdata_held got=%h exp=14..", resp_rdata); end
  endtask

  task automatic test_timeout();
    cyc();
    req_index[2*ADDR_W +: ADDR_W] = 64'h2A0;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_ready got=%b exp=0100", req_ready); end
    cyc();
    req_valid = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL to_early[%0d] got=%b exp=0000", k, resp_done); end
    end
    cyc();
    checks++; if (resp_done !== 4'b0100 || resp_err !== 1'b1) begin errors++; $display("FAIL to_done got=%b/%b exp=0100/1", resp_done, resp_err); end
    checks++; if (resp_rdata !== {64{8'h14}}) begin errors++; $display("FAIL to_rdata got=%h exp=14..", resp_rdata); end
    cyc();
    checks++; if (resp_done !== 4'b0000 || resp_err !== 1'b0) begin errors++; $display("FAIL to_pulse got=%b/%b exp=0000/0", resp_done, resp_err); end
  endtask

  task automatic test_done_at_timeout();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL dt_ready got=%b exp=0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (k == 16) begin
        ddr_operation_done = 1'b1;
        ddr_read_data = {64{8'h99}};
      end
    end
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0010 || resp_err !== 1'b0) begin errors++; $display("FAIL dt_done got=%b/%b exp=0010/0", resp_done, resp_err); end
    checks++; if (resp_rdata !== {64{8'h99}}) begin errors++; $display("FAIL dt_rdata got=%h exp=99..", resp_rdata); end
  endtask

  task automatic test_flush();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fl_ready got=%b exp=0001", req_ready); end
    cyc();
    req_valid = 4'b0000;
    cyc();
    req_flush = 4'b0001;
    cyc();
    req_flush = 4'b0000;
    cyc();
    ddr_operation_done = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL fl_wait_ready got=%b exp=0000", req_ready); end
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL fl_suppressed got=%b exp=0000", resp_done); end
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fl_regrant got=%b exp=0010", req_ready); end
    cyc();
    req_valid = 4'b0000;
    req_flush = 4'b0001;
    cyc();
    req_flush = 4'b0000;
    ddr_operation_done = 1'b1;
    ddr_read_data = {64{8'h77}};
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0010 || resp_rdata !== {64{8'h77}}) begin errors++; $display("FAIL fl_other_ch got=%b/%h exp=0010/77..", resp_done, resp_rdata); end
    req_valid = 4'b0100;
    req_flush = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fl_same_ready got=%b exp=0100", req_ready); end
    cyc();
    req_valid = 4'b0000;
    req_flush = 4'b0000;
    cyc();
    ddr_operation_done = 1'b1;
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL fl_same_done got=%b exp=0000", resp_done); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_ready got=%b exp=1000", req_ready); end
    cyc();
    req_valid = 4'b0000;
    cyc();
    reset_n = 1'b0;
    cyc();
    checks++; if (ddr_chip_enable !== 1'b0 || ddr_index !== 64'h0 || resp_rdata !== {DATA_W{1'b0}}) begin errors++; $display("FAIL rm_outputs got=%b/%h exp=0/0", ddr_chip_enable, ddr_index); end
    reset_n = 1'b1;
    ddr_operation_done = 1'b1;
    cyc();
    ddr_operation_done = 1'b0;
    checks++; if (resp_done !== 4'b0000) begin errors++; $display("FAIL rm_no_done got=%b exp=0000", resp_done); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", req_ready); end
    cyc();
    req_valid = 4'b0000;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = '0; req_write = '0; req_burst = '0; req_flush = '0;
    req_index = '0; req_wdata = '0; req_wmask = '0;
    ddr_read_data = '0; ddr_operation_done = 1'b0; ddr_ready = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_done_at_timeout();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_channel_arb_rr.md
Name: ddr_channel_arb_rr

Overview:
N-channel round-robin arbiter between cache/fetch clients and the single-port DDR sim model. It is the generalised successor of the two-channel fixed-priority icache/dcache arbiter. Each channel uses a valid/ready request handshake. The request is latched at grant, and a one-cycle ddr_chip_enable pulse is issued. A per-channel done pulse is returned when DDR completes. Adds fair rotation, per-channel flush (response drop), a timeout with error flag, and per-request burst/write mode.

Parameters:
NUM_CH, 4, number of requesting channels (>=2)
ADDR_W, 64, request index width
DATA_W, 512, data/mask width
TIMEOUT, 1024, max cycles to wait for ddr_operation_done; 0 disables timeout
CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  one-hot accept strobe
req_index  in  NUM_CH*ADDR_W  channel c at bits [c*ADDR_W +: ADDR_W]
req_write  in  NUM_CH  1=write, 0=read
req_burst  in  NUM_CH  burst read request
req_wdata  in  NUM_CH*DATA_W  write data, packed like req_index
req_wmask  in  NUM_CH*DATA_W  write mask, packed like req_index
req_flush  in  NUM_CH  drop the pending response of this channel
resp_done  out  NUM_CH  one-cycle completion pulse, one-hot
resp_err  out  1  qualifies resp_done: 1 = timed out
resp_rdata  out  DATA_W  read data, valid while resp_done!=0 and held until the next completion
ddr_chip_enable  out  1  one-cycle command pulse
ddr_index  out  ADDR_W  latched index
ddr_write_enable  out  1  latched write flag
ddr_burst_mode  out  1  latched burst flag
ddr_write_data  out  DATA_W  latched write data
ddr_write_mask  out  DATA_W  latched write mask
ddr_read_data  in  DATA_W  DDR read data
ddr_operation_done  in  1  DDR completion
ddr_ready  in  1  DDR can accept a command

Behaviour:
- All outputs are registered. Reset (reset_n=0 at a clock edge) clears all outputs and the latched request, sets state=IDLE and rr_ptr=0. Reset mid-transaction abandons it and produces no resp_done.
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid and ddr_ready, grant the first valid channel at or after rr_ptr (wrapping modulo NUM_CH). Latch index/write/burst/wdata/wmask of the granted channel, pulse req_ready[g] for that cycle, then go to ISSUE. With no valid request or ddr_ready=0, stay in IDLE and drive no ready.
- req_ready is a combinational strobe, the only non-registered output. A client must hold its request stable until it sees req_ready.
- ISSUE: ddr_chip_enable=1 for exactly one cycle with the ddr_* fields driven from the latch, then go to WAIT. ddr_* fields hold their values through WAIT.
- WAIT: the timeout counter increments each cycle.
  - On ddr_operation_done: next cycle resp_done[g]=1, resp_err=0, resp_rdata=ddr_read_data (read; unchanged on write).
  - If counter reaches TIMEOUT first: resp_done[g]=1, resp_err=1, resp_rdata unchanged.
  - Either way, rr_ptr <= (g+1) mod NUM_CH and return to IDLE.
- Latency: grant at cycle T, chip_enable at T+1, done observed at D, resp_done at D+1. Minimum re-grant is at D+1.
- Flush: req_flush[g] asserted at any cycle in ISSUE/WAIT sets a sticky drop flag. The transaction still completes on DDR, but resp_done is suppressed. A flush on a non-granted channel has no effect. Flush and ready in the same cycle: the request is accepted with the drop flag set.
- ddr_operation_done and timeout in the same cycle: done wins, resp_err=0.
- ddr_operation_done in IDLE/ISSUE is ignored.
- rr_ptr wraps from NUM_CH-1 to 0. Grant index width is $clog2(NUM_CH).

Decomposition:
- Package ddr_arb_pkg: state encoding (IDLE/ISSUE/WAIT), DBUS read/write op constants, and the grant-index width function.
- Sub-module rr_arbiter: combinational rotate-priority grant (inputs req[NUM_CH], ptr; outputs one-hot grant and grant index).

Test Plan:
- Single read, ch1: index=0x80, DDR done 5 cycles after chip_enable, rdata=0xAB.. -> ready[1] at T, ce at T+1, resp_done=0b0010 at done+1, resp_rdata=0xAB.., resp_err=0.
- All 4 valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each channel exactly one ready per round.
- Write on ch3, wdata=0x55.., wmask=all-ones -> ddr_write_enable=1, data/mask match at the ce pulse, resp_done[3] pulses.
- DDR never answers, TIMEOUT=16 -> resp_done[g]=1 with resp_err=1 exactly 16 cycles into WAIT, then back to IDLE.
- req_flush[g] pulsed mid-WAIT -> no resp_done on completion; the next request is granted the cycle after done.
- reset_n low during WAIT, then done arrives -> no resp_done, outputs 0, rr_ptr=0.
